// File: rtl/falling_block_ctrl.sv
// rtl/falling_block_ctrl.sv - single falling playfield cell sequencer with pixel bounds
module falling_block_ctrl #(
    parameter int COLS          = 10,
    parameter int ROWS          = 20,
    parameter int CELL          = 16,
    parameter int ORIGIN_X      = 120,
    parameter int ORIGIN_Y      = 20,
    parameter int SPAWN_COL     = 4,
    parameter int GRAVITY_TICKS = 30,
    parameter int SOFT_TICKS    = 2,
    parameter int WIDTH         = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             frame_tick,
    input  logic             move_left,
    input  logic             move_right,
    input  logic             soft_drop,
    input  logic             occ_here,
    input  logic             occ_left,
    input  logic             occ_right,
    input  logic             occ_down,
    output logic [3:0]       col,
    output logic [4:0]       row,
    output logic [WIDTH-1:0] start_x,
    output logic [WIDTH-1:0] stop_x,
    output logic [WIDTH-1:0] start_y,
    output logic [WIDTH-1:0] stop_y,
    output logic             active,
    output logic             landed,
    output logic [3:0]       land_col,
    output logic [4:0]       land_row,
    output logic             game_over
);

    localparam int CNT_W = (GRAVITY_TICKS > 1) ? $clog2(GRAVITY_TICKS + 1) : 1;

    localparam logic [WIDTH-1:0] L_ORG_X   = WIDTH'(ORIGIN_X);
    localparam logic [WIDTH-1:0] L_ORG_Y   = WIDTH'(ORIGIN_Y);
    localparam logic [WIDTH-1:0] L_CELL    = WIDTH'(CELL);
    localparam logic [WIDTH-1:0] L_CELL_M1 = WIDTH'(CELL - 1);
    localparam logic [3:0]       L_SPAWN   = 4'(SPAWN_COL);
    localparam logic [3:0]       L_COL_MAX = 4'(COLS - 1);
    localparam logic [4:0]       L_ROW_MAX = 5'(ROWS - 1);
    localparam logic [CNT_W-1:0] L_GRAV_M1 = CNT_W'(GRAVITY_TICKS - 1);
    localparam logic [CNT_W-1:0] L_SOFT_M1 = CNT_W'(SOFT_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_CHECK,
        S_FALLING,
        S_LANDED,
        S_GAME_OVER
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_col;
    logic [3:0]       w_col_nxt;
    logic [4:0]       r_row;
    logic [4:0]       w_row_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_land_col;
    logic [3:0]       w_land_col_nxt;
    logic [4:0]       r_land_row;
    logic [4:0]       w_land_row_nxt;

    logic             w_move_l;
    logic             w_move_r;
    logic [CNT_W-1:0] w_period_m1;
    logic             w_due;
    logic [WIDTH-1:0] w_start_x;
    logic [WIDTH-1:0] w_start_y;

    // Move legality, active gravity period and due flag for the current position.
    always_comb begin
        w_move_l    = move_left & ~move_right & (r_col != 4'd0) & ~occ_left;
        w_move_r    = move_right & ~move_left & (r_col != L_COL_MAX) & ~occ_right;
        w_period_m1 = soft_drop ? L_SOFT_M1 : L_GRAV_M1;
        w_due       = (r_cnt >= w_period_m1);
    end

    // State, position and counter register; reset wins over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_col      <= L_SPAWN;
            r_row      <= 5'd0;
            r_cnt      <= '0;
            r_land_col <= 4'd0;
            r_land_row <= 5'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_cnt      <= w_cnt_nxt;
            r_land_col <= w_land_col_nxt;
            r_land_row <= w_land_row_nxt;
        end
    end

    // Next-state logic: a tick applies a move first, then gravity; a move on
    // a due tick parks the counter at P-1 so the drop re-evaluates next tick
    // against the new column.
    always_comb begin
        w_state_nxt    = r_state;
        w_col_nxt      = r_col;
        w_row_nxt      = r_row;
        w_cnt_nxt      = r_cnt;
        w_land_col_nxt = r_land_col;
        w_land_row_nxt = r_land_row;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_SPAWN;
            end
            S_SPAWN: begin
                w_col_nxt   = L_SPAWN;
                w_row_nxt   = 5'd0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                w_state_nxt = occ_here ? S_GAME_OVER : S_FALLING;
            end
            S_FALLING: begin
                if (frame_tick) begin
                    if (w_move_l) w_col_nxt = r_col - 4'd1;
                    if (w_move_r) w_col_nxt = r_col + 4'd1;
                    if ((w_move_l | w_move_r) && w_due) begin
                        w_cnt_nxt = w_period_m1;
                    end else if (w_due) begin
                        w_cnt_nxt = '0;
                        if ((r_row == L_ROW_MAX) || occ_down) begin
                            w_state_nxt    = S_LANDED;
                            w_land_col_nxt = r_col;
                            w_land_row_nxt = r_row;
                        end else begin
                            w_row_nxt = r_row + 5'd1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_LANDED: begin
                w_state_nxt = S_SPAWN;
            end
            S_GAME_OVER: begin
                if (start) w_state_nxt = S_SPAWN;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pixel bounds follow the registered position combinationally.
    always_comb begin
        w_start_x = L_ORG_X + WIDTH'(r_col) * L_CELL;
        w_start_y = L_ORG_Y + WIDTH'(r_row) * L_CELL;
    end

    assign start_x   = w_start_x;
    assign stop_x    = w_start_x + L_CELL_M1;
    assign start_y   = w_start_y;
    assign stop_y    = w_start_y + L_CELL_M1;
    assign col       = r_col;
    assign row       = r_row;
    assign active    = (r_state == S_FALLING);
    assign landed    = (r_state == S_LANDED);
    assign land_col  = r_land_col;
    assign land_row  = r_land_row;
    assign game_over = (r_state == S_GAME_OVER);

endmodule

// File: tb/tb_falling_block_ctrl.sv
// tb/tb_falling_block_ctrl.sv - vector table and sequences for falling_block_ctrl
module tb_falling_block_ctrl;

    localparam int WIDTH = 11;

    logic             clock;
    logic             reset;
    logic             start;
    logic             frame_tick;
    logic             move_left;
    logic             move_right;
    logic             soft_drop;
    logic             occ_here;
    logic             occ_left;
    logic             occ_right;
    logic             occ_down;
    logic [3:0]       col;
    logic [4:0]       row;
    logic [WIDTH-1:0] start_x;
    logic [WIDTH-1:0] stop_x;
    logic [WIDTH-1:0] start_y;
    logic [WIDTH-1:0] stop_y;
    logic             active;
    logic             landed;
    logic [3:0]       land_col;
    logic [4:0]       land_row;
    logic             game_over;

    falling_block_ctrl #(
        .GRAVITY_TICKS(4),
        .SOFT_TICKS   (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .frame_tick(frame_tick),
        .move_left (move_left),
        .move_right(move_right),
        .soft_drop (soft_drop),
        .occ_here  (occ_here),
        .occ_left  (occ_left),
        .occ_right (occ_right),
        .occ_down  (occ_down),
        .col       (col),
        .row       (row),
        .start_x   (start_x),
        .stop_x    (stop_x),
        .start_y   (start_y),
        .stop_y    (stop_y),
        .active    (active),
        .landed    (landed),
        .land_col  (land_col),
        .land_row  (land_row),
        .game_over (game_over)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic l;
        logic r;
        logic sd;
        logic ocl;
        logic ocr;
        logic ocd;
        int   col;
        int   row;
        logic lnd;
    } vec_t;

    vec_t vecs[29];
    int   n_cmp;
    int   n_bad;

    function automatic vec_t mk(input logic l, input logic r, input logic sd,
                                input logic ocl, input logic ocr, input logic ocd,
                                input int c, input int rw, input logic lnd);
        vec_t v;
        v.l = l; v.r = r; v.sd = sd; v.ocl = ocl; v.ocr = ocr; v.ocd = ocd;
        v.col = c; v.row = rw; v.lnd = lnd;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic tick_once();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " active"}, int'(active), 0);
        chk({tag, " col"}, int'(col), 4);
        chk({tag, " row"}, int'(row), 0);
        chk({tag, " landed"}, int'(landed), 0);
        chk({tag, " land_col"}, int'(land_col), 0);
        chk({tag, " land_row"}, int'(land_row), 0);
        chk({tag, " game_over"}, int'(game_over), 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1; start = 1'b0; frame_tick = 1'b0;
        move_left = 1'b0; move_right = 1'b0; soft_drop = 1'b0;
        occ_here = 1'b0; occ_left = 1'b0; occ_right = 1'b0; occ_down = 1'b0;

        vecs[0]  = mk(1,0,0,0,0,0, 3,0,0);
        vecs[1]  = mk(1,0,0,0,0,0, 2,0,0);
        vecs[2]  = mk(1,0,0,1,0,0, 2,0,0);
        vecs[3]  = mk(1,1,0,0,0,0, 2,1,0);
        vecs[4]  = mk(1,0,0,0,0,0, 1,1,0);
        vecs[5]  = mk(1,0,0,0,0,0, 0,1,0);
        vecs[6]  = mk(1,0,0,0,0,0, 0,1,0);
        vecs[7]  = mk(1,0,0,0,0,0, 0,2,0);
        vecs[8]  = mk(0,1,0,0,0,0, 1,2,0);
        vecs[9]  = mk(0,1,0,0,1,0, 1,2,0);
        vecs[10] = mk(0,0,0,0,0,0, 1,2,0);
        vecs[11] = mk(0,1,0,0,0,0, 2,2,0);
        vecs[12] = mk(0,0,0,0,0,0, 2,3,0);
        vecs[13] = mk(0,0,1,0,0,0, 2,3,0);
        vecs[14] = mk(0,0,1,0,0,0, 2,4,0);
        vecs[15] = mk(0,0,1,0,0,0, 2,4,0);
        vecs[16] = mk(0,0,1,0,0,0, 2,5,0);
        vecs[17] = mk(0,0,1,0,0,0, 2,5,0);
        vecs[18] = mk(0,0,0,0,0,0, 2,5,0);
        vecs[19] = mk(0,0,0,0,0,0, 2,5,0);
        vecs[20] = mk(0,0,0,0,0,0, 2,6,0);
        vecs[21] = mk(0,0,0,0,0,0, 2,6,0);
        vecs[22] = mk(0,0,0,0,0,0, 2,6,0);
        vecs[23] = mk(0,0,1,0,0,0, 2,7,0);
        vecs[24] = mk(0,0,0,0,0,0, 2,7,0);
        vecs[25] = mk(0,0,0,0,0,0, 2,7,0);
        vecs[26] = mk(0,0,0,0,0,0, 2,7,0);
        vecs[27] = mk(0,1,0,0,0,0, 3,7,0);
        vecs[28] = mk(0,0,0,0,0,1, 3,7,1);

        // reset values
        @(negedge clock);
        step();
        chk_reset_vals("reset");
        reset = 1'b0;
        step();

        // start then two cycles to FALLING
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("spawn active", int'(active), 1);
        chk("spawn col", int'(col), 4);
        chk("spawn row", int'(row), 0);
        chk("spawn start_x", int'(start_x), 184);
        chk("spawn stop_x", int'(stop_x), 199);
        chk("spawn start_y", int'(start_y), 20);
        chk("spawn stop_y", int'(stop_y), 35);
        chk("spawn landed", int'(landed), 0);
        chk("spawn game_over", int'(game_over), 0);

        // levels without frame_tick and a stray start change nothing
        move_left = 1'b1;
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        move_left = 1'b0;
        chk("notick col", int'(col), 4);
        chk("notick row", int'(row), 0);
        chk("start ignored active", int'(active), 1);

        // table of single-tick vectors
        for (int i = 0; i < 29; i++) begin
            move_left  = vecs[i].l;
            move_right = vecs[i].r;
            soft_drop  = vecs[i].sd;
            occ_left   = vecs[i].ocl;
            occ_right  = vecs[i].ocr;
            occ_down   = vecs[i].ocd;
            tick_once();
            chk($sformatf("vec%0d col", i), int'(col), vecs[i].col);
            chk($sformatf("vec%0d row", i), int'(row), vecs[i].row);
            chk($sformatf("vec%0d landed", i), int'(landed), int'(vecs[i].lnd));
            chk($sformatf("vec%0d active", i), int'(active), int'(!vecs[i].lnd));
            chk($sformatf("vec%0d start_x", i), int'(start_x), 120 + 16 * vecs[i].col);
            chk($sformatf("vec%0d stop_y", i), int'(stop_y), 20 + 16 * vecs[i].row + 15);
            if (vecs[i].col == 0) chk($sformatf("vec%0d wall start_x", i), int'(start_x), 120);
        end
        move_left = 1'b0; move_right = 1'b0; soft_drop = 1'b0;
        occ_left = 1'b0; occ_right = 1'b0; occ_down = 1'b0;
        chk("land_col occ", int'(land_col), 3);
        chk("land_row occ", int'(land_row), 7);

        // ticks during LANDED/SPAWN/CHECK are ignored
        frame_tick = 1'b1;
        step();
        chk("landed pulse one cycle", int'(landed), 0);
        chk("spawn inactive", int'(active), 0);
        step();
        frame_tick = 1'b0;
        chk("respawn row", int'(row), 0);
        chk("respawn col", int'(col), 4);
        step();
        chk("respawn active", int'(active), 1);

        // free fall to the floor
        for (int t = 1; t < 80; t++) begin
            tick_once();
            chk($sformatf("fall t%0d row", t), int'(row), t / 4);
            chk($sformatf("fall t%0d landed", t), int'(landed), 0);
        end
        tick_once();
        chk("floor landed", int'(landed), 1);
        chk("floor active", int'(active), 0);
        chk("floor land_col", int'(land_col), 4);
        chk("floor land_row", int'(land_row), 19);
        step();
        chk("floor landed clear", int'(landed), 0);
        step();
        chk("floor respawn row", int'(row), 0);
        step();
        chk("floor respawn active", int'(active), 1);

        // reset mid-fall at row 7
        for (int t = 0; t < 28; t++) tick_once();
        chk("midfall row", int'(row), 7);
        reset = 1'b1;
        step();
        chk_reset_vals("midreset");
        reset = 1'b0;
        step();

        // game over on occupied spawn cell, then restart
        occ_here = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("go spawn landed", int'(landed), 0);
        step();
        chk("go check landed", int'(landed), 0);
        step();
        chk("go game_over", int'(game_over), 1);
        chk("go active", int'(active), 0);
        chk("go landed", int'(landed), 0);
        step();
        chk("go held", int'(game_over), 1);
        occ_here = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart game_over", int'(game_over), 0);
        chk("restart active", int'(active), 0);
        step();
        step();
        chk("restart falling", int'(active), 1);
        chk("restart row", int'(row), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
